// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice frame tracker and the colour-filter display path.
// Holds the FSM state type, the RGB565 field positions and the common red-pixel test.
package dice_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        COUNT     = 2'd1,
        CLASSIFY  = 2'd2,
        FILTER    = 2'd3
    } state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    // Green is compared at 5-bit scale (g[5:1]); 7-bit sums cannot wrap.
    function automatic logic is_red_565(input logic [15:0] pixel, input int r_min, input int margin);
        logic [6:0] r7;
        logic [6:0] g7;
        logic [6:0] b7;
        logic [6:0] m7;
        logic [6:0] t7;
        r7 = {2'b00, pixel[R_MSB:R_LSB]};
        g7 = {2'b00, pixel[G_MSB:G_LSB+1]};
        b7 = {2'b00, pixel[B_MSB:B_LSB]};
        m7 = 7'(margin);
        t7 = 7'(r_min);
        return (r7 > t7) && (r7 > (g7 + m7)) && (r7 > (b7 + m7));
    endfunction

endpackage

// File: rtl/dice_stability_filter.sv
// Debounces the per-frame classification: the reported value only moves after
// STABLE_FRAMES identical consecutive classifications.
module dice_stability_filter
    import dice_pkg::*;
#(
    parameter int STABLE_FRAMES = 3
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       strobe,
    input  logic [2:0] raw_value,
    output logic [2:0] dice_value,
    output logic       value_valid,
    output logic       value_changed
);

    localparam int RUN_W = $clog2(STABLE_FRAMES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_FRAMES);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [2:0]       candidate_r;
    logic [RUN_W-1:0] run_r;
    logic [2:0]       candidate_s;
    logic [RUN_W-1:0] run_s;
    logic             commit_s;

    // Next candidate/run and commit decision for the current strobe.
    always_comb begin
        candidate_s = candidate_r;
        run_s       = run_r;
        commit_s    = 1'b0;
        if (strobe) begin
            if (raw_value == candidate_r) begin
                if (run_r < RUN_MAX) begin
                    run_s = run_r + RUN_ONE;
                end else begin
                    run_s = RUN_MAX;
                end
            end else begin
                candidate_s = raw_value;
                run_s       = RUN_ONE;
            end
            commit_s = (run_s == RUN_MAX) && (!value_valid || (candidate_s != dice_value));
        end else begin
            commit_s = 1'b0;
        end
    end

    // Candidate tracking and registered value outputs.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            candidate_r   <= 3'd0;
            run_r         <= '0;
            dice_value    <= 3'd0;
            value_valid   <= 1'b0;
            value_changed <= 1'b0;
        end else begin
            candidate_r   <= candidate_s;
            run_r         <= run_s;
            value_changed <= commit_s;
            if (commit_s) begin
                dice_value  <= candidate_s;
                value_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dice_frame_tracker.sv
// Per-frame red-pixel counter on the pclk RGB565 stream: counts red pixels inside
// a region of interest, classifies the count into a pip value and debounces it.
module dice_frame_tracker
    import dice_pkg::*;
#(
    parameter int CNT_W         = 20,
    parameter int R_MIN         = 10,
    parameter int MARGIN        = 2,
    parameter int X0            = 0,
    parameter int X1            = 319,
    parameter int Y0            = 0,
    parameter int Y1            = 239,
    parameter int MIN_CNT       = 125,
    parameter int UNIT          = 250,
    parameter int MAX_VAL       = 6,
    parameter int STABLE_FRAMES = 3
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             href,
    input  logic             we,
    input  logic [15:0]      pixel_in,
    output logic [2:0]       dice_value,
    output logic             value_valid,
    output logic             value_changed,
    output logic             frame_done,
    output logic [CNT_W-1:0] red_count,
    output logic [2:0]       raw_value
);

    localparam int POS_W = CNT_W / 2;
    localparam logic [POS_W-1:0] X0_C    = POS_W'(X0);
    localparam logic [POS_W-1:0] Y0_C    = POS_W'(Y0);
    localparam logic [POS_W-1:0] XSPAN_C = POS_W'(X1 - X0);
    localparam logic [POS_W-1:0] YSPAN_C = POS_W'(Y1 - Y0);
    localparam logic [POS_W-1:0] POS_MAX = {POS_W{1'b1}};
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Compare chain against MIN_CNT + k*UNIT; thresholds rise with k so the last hit wins.
    function automatic logic [2:0] classify(input logic [CNT_W-1:0] cnt);
        logic [2:0] v;
        v = 3'd0;
        for (int k = 0; k < MAX_VAL; k++) begin
            if (64'(cnt) >= (64'(MIN_CNT) + (64'(k) * 64'(UNIT)))) begin
                v = 3'(k + 1);
            end
        end
        return v;
    endfunction

    logic             vsync_q_r;
    logic             href_q_r;
    logic             rise_s;
    logic             href_fall_s;
    state_t           state_r;
    state_t           state_s;
    logic [POS_W-1:0] x_r;
    logic [POS_W-1:0] y_r;
    logic [CNT_W-1:0] count_r;
    logic             in_roi_s;
    logic             hit_s;
    logic             frame_end_s;

    assign rise_s      = vsync && !vsync_q_r;
    assign href_fall_s = !href && href_q_r;
    assign frame_end_s = (state_r == COUNT) && rise_s;
    // Offset-and-span test: below-window coordinates wrap to large values and fail.
    assign in_roi_s    = ((x_r - X0_C) <= XSPAN_C) && ((y_r - Y0_C) <= YSPAN_C);
    assign hit_s       = we && !vsync && is_red_565(pixel_in, R_MIN, MARGIN) && in_roi_s
                         && (state_r != WAIT_SYNC);

    // Registered sync copies for edge detection.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            vsync_q_r <= 1'b0;
            href_q_r  <= 1'b0;
        end else begin
            vsync_q_r <= vsync;
            href_q_r  <= href;
        end
    end

    // FSM state register.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_r <= WAIT_SYNC;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state; rises outside WAIT_SYNC/COUNT fold the frame into the next one.
    always_comb begin
        state_s = state_r;
        case (state_r)
            WAIT_SYNC: begin
                if (rise_s) begin
                    state_s = COUNT;
                end else begin
                    state_s = WAIT_SYNC;
                end
            end
            COUNT: begin
                if (rise_s) begin
                    state_s = CLASSIFY;
                end else begin
                    state_s = COUNT;
                end
            end
            CLASSIFY: state_s = FILTER;
            FILTER:   state_s = COUNT;
            default:  state_s = WAIT_SYNC;
        endcase
    end

    // Pixel position within the frame, saturating.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            x_r <= '0;
            y_r <= '0;
        end else begin
            if (rise_s || href_fall_s) begin
                x_r <= '0;
            end else if (we && (x_r != POS_MAX)) begin
                x_r <= x_r + POS_ONE;
            end
            if (rise_s) begin
                y_r <= '0;
            end else if (href_fall_s && (y_r != POS_MAX)) begin
                y_r <= y_r + POS_ONE;
            end
        end
    end

    // Saturating red-pixel counter for the frame in progress.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (frame_end_s) begin
            count_r <= '0;
        end else if (hit_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    // Frame results, visible during the CLASSIFY cycle.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            red_count  <= '0;
            raw_value  <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end_s;
            if (frame_end_s) begin
                red_count <= count_r;
                raw_value <= classify(count_r);
            end
        end
    end

    dice_stability_filter #(
        .STABLE_FRAMES(STABLE_FRAMES)
    ) u_filter (
        .pclk          (pclk),
        .reset         (reset),
        .strobe        (frame_done),
        .raw_value     (raw_value),
        .dice_value    (dice_value),
        .value_valid   (value_valid),
        .value_changed (value_changed)
    );

endmodule
